line_buf_ctrl: RTL and testbench

Ping-pong controller for the two MEM2048X24 line buffers that feed the UM (unsharp mask) stage. Each active pixel is written into one bank while the same column of the previous line is read from the other bank. The banks swap at every end of line. Output is the current pixel, aligned with its vertically adjacent previous-line pixel plus x/y coordinates, so downstream vertical filters need no memory handling of their own.

---
 rtl/line_buf_ctrl_if.sv | 38 +++
 rtl/line_buf_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_line_buf_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/line_buf_ctrl_if.sv
// ---------------------------------------------------------------------------
// line_buf_ctrl_if
// Memory-side bus between line_buf_ctrl and its two MEM2048X24 line-buffer
// banks. Signal names follow the per-bank naming used by the memory macros.
//   master : controller side (drives cs/web/re/addresses/din, samples dout)
//   slave  : memory side (samples controls, drives dout one cycle after re)
// ---------------------------------------------------------------------------
interface line_buf_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              mem1_cs;
  logic              mem1_web;
  logic              mem1_re;
  logic [ADDR_W-1:0] mem1_w_addr;
  logic [ADDR_W-1:0] mem1_r_addr;
  logic [23:0]       mem1_din;
  logic [23:0]       mem1_dout;

  logic              mem2_cs;
  logic              mem2_web;
  logic              mem2_re;
  logic [ADDR_W-1:0] mem2_w_addr;
  logic [ADDR_W-1:0] mem2_r_addr;
  logic [23:0]       mem2_din;
  logic [23:0]       mem2_dout;

  modport master (
    output mem1_cs, mem1_web, mem1_re, mem1_w_addr, mem1_r_addr, mem1_din,
    output mem2_cs, mem2_web, mem2_re, mem2_w_addr, mem2_r_addr, mem2_din,
    input  mem1_dout, mem2_dout
  );

  modport slave (
    input  mem1_cs, mem1_web, mem1_re, mem1_w_addr, mem1_r_addr, mem1_din,
    input  mem2_cs, mem2_web, mem2_re, mem2_w_addr, mem2_r_addr, mem2_din,
    output mem1_dout, mem2_dout
  );
endinterface

// File: rtl/line_buf_ctrl.sv
// ---------------------------------------------------------------------------
// line_buf_ctrl
// Ping-pong controller for the two line buffers feeding the unsharp-mask
// stage. Each accepted pixel is written to bank wr_sel while the same column
// of the previous line is read from the other bank; banks swap at end of line.
// Output is the current pixel delayed one cycle, aligned with the pixel
// directly above it, plus its x/y coordinates.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              block enable (0 = memories idle, FSM parked in IDLE)
//   vsync, den      frame start, data enable
//   pix_in          RGB888 current pixel
//   mem             line_buf_ctrl_if.master, both memory banks
//   pix_out/prev_out current pixel / previous-line pixel, same column
//   out_valid/prev_valid qualifiers for pix_out / prev_out
//   out_x, out_y    coordinates of pix_out
//   ovf             sticky overrun flag, cleared by vsync or rst
// ---------------------------------------------------------------------------
module line_buf_ctrl #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int ADDR_W   = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  vsync,
  input  logic                  den,
  input  logic [23:0]           pix_in,
  line_buf_ctrl_if.master       mem,
  output logic [23:0]           pix_out,
  output logic [23:0]           prev_out,
  output logic                  out_valid,
  output logic                  prev_valid,
  output logic [10:0]           out_x,
  output logic [10:0]           out_y,
  output logic                  ovf
);

  // One extra bit so x can sit at H_ACTIVE even when 2**ADDR_W == H_ACTIVE.
  localparam int XW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [10:0]   y_q, y_d;
  logic          wr_sel_q, wr_sel_d;     // bank being written: 0=mem1, 1=mem2
  logic          rd_bank_q, rd_bank_d;   // bank read for the pixel now on pix_out
  logic          den_dly_q, den_dly_d;
  logic          done_q, done_d;         // a full frame completed since last vsync
  logic          ovf_q, ovf_d;
  logic          out_valid_q, out_valid_d;
  logic          prev_valid_q, prev_valid_d;
  logic [23:0]   pix_out_q, pix_out_d;
  logic [10:0]   out_x_q, out_x_d;
  logic [10:0]   out_y_q, out_y_d;

  logic accept;
  logic rd_en;
  logic wr1, wr2, rd1, rd2;

  // NOTE: rst is folded into accept so memory controls are idle during reset
  // even though they are combinational and not held in flops.
  assign accept = !rst && en && den && !vsync && (state_q != IDLE) &&
                  (x_q < XW'(H_ACTIVE));
  assign rd_en  = accept && (state_q == RUN);
  assign wr1    = accept && !wr_sel_q;
  assign wr2    = accept &&  wr_sel_q;
  assign rd1    = rd_en  &&  wr_sel_q;
  assign rd2    = rd_en  && !wr_sel_q;

  // Memory controls are issued in the accept cycle so read data arrives
  // exactly when the registered pixel appears on pix_out.
  always_comb begin
    mem.mem1_cs     = wr1 || rd1;
    mem.mem1_web    = !wr1;
    mem.mem1_re     = rd1;
    mem.mem1_w_addr = wr1 ? x_q[ADDR_W-1:0] : '0;
    mem.mem1_r_addr = rd1 ? x_q[ADDR_W-1:0] : '0;
    mem.mem1_din    = wr1 ? pix_in : '0;
    mem.mem2_cs     = wr2 || rd2;
    mem.mem2_web    = !wr2;
    mem.mem2_re     = rd2;
    mem.mem2_w_addr = wr2 ? x_q[ADDR_W-1:0] : '0;
    mem.mem2_r_addr = rd2 ? x_q[ADDR_W-1:0] : '0;
    mem.mem2_din    = wr2 ? pix_in : '0;
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path infers a latch.
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    wr_sel_d     = wr_sel_q;
    rd_bank_d    = rd_bank_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    out_valid_d  = 1'b0;
    prev_valid_d = 1'b0;
    pix_out_d    = pix_out_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    // A vsync or disable discards any partial line, so no end of line follows.
    den_dly_d    = den && en && !vsync;

    if (!en) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (vsync) begin
      state_d  = FILL;
      x_d      = '0;
      y_d      = '0;
      wr_sel_d = 1'b0;
      ovf_d    = 1'b0;
      done_d   = 1'b0;
    end else begin
      if (accept) begin
        x_d          = x_q + XW'(1);
        out_valid_d  = 1'b1;
        prev_valid_d = (state_q == RUN);
        pix_out_d    = pix_in;
        out_x_d      = 11'(x_q);
        out_y_d      = y_q;
        rd_bank_d    = !wr_sel_q;
      end else if (den && (state_q != IDLE || done_q)) begin
        // Line longer than H_ACTIVE, or pixels after the frame ended.
        ovf_d = 1'b1;
      end

      if (state_q != IDLE && den_dly_q && !den) begin
        x_d = '0;
        y_d = y_q + 11'd1;
        if (y_q == 11'(V_ACTIVE - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          wr_sel_d = !wr_sel_q;
          if (state_q == FILL) state_d = RUN;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the memory
  // arrays live outside this block and are never cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      wr_sel_q     <= 1'b0;
      rd_bank_q    <= 1'b0;
      den_dly_q    <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      pix_out_q    <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wr_sel_q     <= wr_sel_d;
      rd_bank_q    <= rd_bank_d;
      den_dly_q    <= den_dly_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      prev_valid_q <= prev_valid_d;
      pix_out_q    <= pix_out_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
    end
  end

  assign pix_out    = pix_out_q;
  assign out_valid  = out_valid_q;
  assign prev_valid = prev_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign ovf        = ovf_q;
  assign prev_out   = !prev_valid_q ? 24'd0 :
                      (rd_bank_q ? mem.mem2_dout : mem.mem1_dout);

endmodule

// File: tb/tb_line_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_buf_ctrl
// Directed bench for line_buf_ctrl with a two-bank memory model. The driver
// checks memory controls each cycle and pushes expected output beats into a
// queue; an independent monitor pops and compares whenever out_valid is high.
// V_ACTIVE is reduced to 4 so end-of-frame behaviour is reachable quickly.
// ---------------------------------------------------------------------------
module tb_line_buf_ctrl;
  localparam int H = 1920;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        vsync = 1'b0;
  logic        den = 1'b0;
  logic [23:0] pix_in = '0;
  logic [23:0] pix_out, prev_out;
  logic        out_valid, prev_valid, ovf;
  logic [10:0] out_x, out_y;

  always #5 clk = ~clk;

  line_buf_ctrl_if #(.ADDR_W(11)) mem_bus ();

  line_buf_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .vsync      (vsync),
    .den        (den),
    .pix_in     (pix_in),
    .mem        (mem_bus),
    .pix_out    (pix_out),
    .prev_out   (prev_out),
    .out_valid  (out_valid),
    .prev_valid (prev_valid),
    .out_x      (out_x),
    .out_y      (out_y),
    .ovf        (ovf)
  );

  // Memory model: write on edge, read data registered one cycle after re.
  logic [23:0] bank1 [2048];
  logic [23:0] bank2 [2048];
  always @(posedge clk) begin
    if (mem_bus.mem1_cs && !mem_bus.mem1_web) bank1[mem_bus.mem1_w_addr] <= mem_bus.mem1_din;
    if (mem_bus.mem1_cs &&  mem_bus.mem1_re)  mem_bus.mem1_dout <= bank1[mem_bus.mem1_r_addr];
    if (mem_bus.mem2_cs && !mem_bus.mem2_web) bank2[mem_bus.mem2_w_addr] <= mem_bus.mem2_din;
    if (mem_bus.mem2_cs &&  mem_bus.mem2_re)  mem_bus.mem2_dout <= bank2[mem_bus.mem2_r_addr];
  end

  typedef struct {
    logic [23:0] pix;
    int          x;
    int          y;
    bit          pv;
    logic [23:0] prev;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented output beat against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pix_out",    32'(pix_out),    32'(e.pix));
        check("out_x",      32'(out_x),      32'(e.x));
        check("out_y",      32'(out_y),      32'(e.y));
        check("prev_valid", 32'(prev_valid), 32'(e.pv));
        check("prev_out",   32'(prev_out),   32'(e.prev));
      end
    end
  end

  // One cycle of stimulus. wb/rb: expected write/read bank (0 none, 1, 2).
  task automatic cyc(input bit vs, input bit de, input bit e, input logic [23:0] px,
                     input int wb, input int rb, input int ad);
    vsync  = vs;
    den    = de;
    en     = e;
    pix_in = px;
    @(negedge clk);
    check("mem1_cs_web_re", 32'({mem_bus.mem1_cs, mem_bus.mem1_web, mem_bus.mem1_re}),
          32'({wb == 1 || rb == 1, wb != 1, rb == 1}));
    check("mem2_cs_web_re", 32'({mem_bus.mem2_cs, mem_bus.mem2_web, mem_bus.mem2_re}),
          32'({wb == 2 || rb == 2, wb != 2, rb == 2}));
    if (wb == 1) begin
      check("mem1_w_addr", 32'(mem_bus.mem1_w_addr), 32'(ad));
      check("mem1_din",    32'(mem_bus.mem1_din),    32'(px));
    end
    if (wb == 2) begin
      check("mem2_w_addr", 32'(mem_bus.mem2_w_addr), 32'(ad));
      check("mem2_din",    32'(mem_bus.mem2_din),    32'(px));
    end
    if (rb == 1) check("mem1_r_addr", 32'(mem_bus.mem1_r_addr), 32'(ad));
    if (rb == 2) check("mem2_r_addr", 32'(mem_bus.mem2_r_addr), 32'(ad));
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 24'd0, 0, 0, 0);
  endtask

  // n_tot den cycles; the first H are accepted, the rest are overrun drops.
  task automatic line(input int n_tot, input logic [23:0] base, input int y,
                      input int wb, input bit pv, input logic [23:0] prev_base);
    for (int i = 0; i < n_tot; i++) begin
      if (i < H) begin
        exp_t e;
        e.pix  = base + 24'(i);
        e.x    = i;
        e.y    = y;
        e.pv   = pv;
        e.prev = pv ? prev_base + 24'(i) : 24'd0;
        exp_q.push_back(e);
        cyc(1'b0, 1'b1, 1'b1, base + 24'(i), wb, pv ? 3 - wb : 0, i);
      end else begin
        cyc(1'b0, 1'b1, 1'b1, base + 24'(i), 0, 0, 0);
      end
    end
  endtask

  initial begin
    // Reset held 3 cycles with den asserted.
    rst = 1'b1;
    den = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mem1_ctrl", 32'({mem_bus.mem1_cs, mem_bus.mem1_web, mem_bus.mem1_re}), 32'b010);
      check("rst_mem2_ctrl", 32'({mem_bus.mem2_cs, mem_bus.mem2_web, mem_bus.mem2_re}), 32'b010);
    end
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_prev_valid", 32'(prev_valid), 32'd0);
    check("rst_pix_out",    32'(pix_out),    32'd0);
    check("rst_prev_out",   32'(prev_out),   32'd0);
    check("rst_out_x",      32'(out_x),      32'd0);
    check("rst_out_y",      32'(out_y),      32'd0);
    check("rst_ovf",        32'(ovf),        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    den = 1'b0;

    // IDLE ignores den before any frame.
    cyc(1'b0, 1'b1, 1'b1, 24'h0000aa, 0, 0, 0);
    gap(2);
    check("idle_den_no_ovf", 32'(ovf), 32'd0);

    // Frame 1: fill, run, bank swap, short lines, end of frame.
    cyc(1'b1, 1'b0, 1'b1, 24'd0, 0, 0, 0);
    line(H, 24'h000000, 0, 1, 1'b0, 24'h0);
    gap(3);
    line(H, 24'h100000, 1, 2, 1'b1, 24'h000000);
    gap(3);
    line(8, 24'h200000, 2, 1, 1'b1, 24'h100000);
    gap(3);
    line(8, 24'h300000, 3, 2, 1'b1, 24'h200000);
    gap(3);
    check("ovf_after_frame", 32'(ovf), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 24'h3000aa, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 24'h3000bb, 0, 0, 0);
    gap(1);
    check("ovf_den_after_frame", 32'(ovf), 32'd1);

    // Frame 2: vsync clears ovf; 1925-pixel line overruns.
    cyc(1'b1, 1'b0, 1'b1, 24'd0, 0, 0, 0);
    check("ovf_cleared_vsync1", 32'(ovf), 32'd0);
    line(H + 5, 24'h400000, 0, 1, 1'b0, 24'h0);
    gap(1);
    check("ovf_overrun", 32'(ovf), 32'd1);
    gap(2);

    // Frame 3: vsync clears ovf; vsync lands mid-line at x=700 with den=1.
    cyc(1'b1, 1'b0, 1'b1, 24'd0, 0, 0, 0);
    check("ovf_cleared_vsync2", 32'(ovf), 32'd0);
    line(700, 24'h500000, 0, 1, 1'b0, 24'h0);
    cyc(1'b1, 1'b1, 1'b1, 24'h5002bc, 0, 0, 0);
    gap(3);
    line(8, 24'h600000, 0, 1, 1'b0, 24'h0);
    gap(3);
    line(4, 24'h700000, 1, 2, 1'b1, 24'h600000);

    // Disable mid-RUN, then re-enable without vsync.
    cyc(1'b0, 1'b1, 1'b0, 24'h700004, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 24'h7000aa, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 24'h7000bb, 0, 0, 0);
    gap(3);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
